// File: rtl/urv_trap_ctrl_pkg.sv
// Shared CSR addresses, implemented bit positions, interrupt cause codes and FSM encoding.
// Imported by the trap controller and its helpers.
package urv_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int IRQ_MT       = 7;
    localparam int IRQ_ME       = 11;

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } trap_state_e;

    // External interrupt outranks the timer when both are enabled and pending.
    function automatic logic [31:0] irq_mcause(input logic meip_pend);
        return {1'b1, 27'b0, (meip_pend ? CAUSE_MEI : CAUSE_MTI)};
    endfunction

endpackage

// File: rtl/urv_trap_ctrl_irq_sync.sv
// Optional two-flop synchroniser for the level-sensitive external interrupt line.
// Adds two cycles of latency when SYNC=1, none when SYNC=0.
module urv_trap_ctrl_irq_sync #(
    parameter bit SYNC = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    output logic irq_o
);

    generate
        if (SYNC) begin : g_sync
            logic r_meta;
            logic r_sync;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                end else begin
                    r_meta <= irq_i;
                    r_sync <= r_meta;
                end
            end

            assign irq_o = r_sync;
        end else begin : g_direct
            logic w_unused;
            assign w_unused = clk_i ^ rst_i;
            assign irq_o    = irq_i;
        end
    endgenerate

endmodule

// File: rtl/urv_trap_ctrl.sv
// Machine-mode trap CSRs plus trap-entry / mret sequencing; redirect is registered (event N -> pulse N+1).
// No backpressure: stall/kill simply freeze CSR state; the one REDIRECT cycle ignores execute inputs.
module urv_trap_ctrl
    import urv_trap_ctrl_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0008,
    parameter bit          IRQ_SYNC    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic [31:0] x_pc_i,
    input  logic        x_csr_write_i,
    input  logic [11:0] x_csr_sel_i,
    input  logic [31:0] x_csr_write_value_i,
    input  logic        x_exception_i,
    input  logic [3:0]  x_exception_cause_i,
    input  logic        x_is_mret_i,
    input  logic        irq_i,
    input  logic        timer_tick_i,
    output logic        x_redirect_o,
    output logic [31:0] x_redirect_pc_o,
    output logic        x_interrupt_o,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o
);

    trap_state_e r_state;
    trap_state_e w_state_nxt;

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_mtie;
    logic        r_mie_meie;
    logic        r_mtip;
    logic [31:2] r_mtvec;
    logic [31:2] r_mepc;
    logic [31:0] r_mcause;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;

    logic w_meip;
    logic w_advance;
    logic w_meip_pend;
    logic w_mtip_pend;
    logic w_exc;
    logic w_irq_take;
    logic w_trap;
    logic w_mret;
    logic w_csr_wr;
    logic w_unused;

    urv_trap_ctrl_irq_sync #(
        .SYNC (IRQ_SYNC)
    ) u_irq_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .irq_i (irq_i),
        .irq_o (w_meip)
    );

    assign w_unused = ^x_pc_i[1:0];

    // Reset also gates advance so the combinational interrupt pulse stays low during reset.
    assign w_advance   = !rst_i && !x_stall_i && !x_kill_i && (r_state == ST_IDLE);
    assign w_meip_pend = w_meip & r_mie_meie;
    assign w_mtip_pend = r_mtip & r_mie_mtie;
    assign w_exc       = w_advance && x_exception_i;
    assign w_irq_take  = w_advance && r_mstatus_mie && (w_meip_pend || w_mtip_pend) && !x_exception_i;
    assign w_trap      = w_exc || w_irq_take;
    assign w_mret      = w_advance && x_is_mret_i && !w_trap;
    assign w_csr_wr    = w_advance && x_csr_write_i && !w_trap && !x_is_mret_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_trap || w_mret) w_state_nxt = ST_REDIRECT;
            ST_REDIRECT: w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Timer pending bit latches even while execute is frozen; a tick beats a clearing write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mtip <= 1'b0;
        end else if (timer_tick_i) begin
            r_mtip <= 1'b1;
        end else if (w_csr_wr && (x_csr_sel_i == CSR_MIP)) begin
            r_mtip <= x_csr_write_value_i[IRQ_MT];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_mtie     <= 1'b0;
            r_mie_meie     <= 1'b0;
            r_mtvec        <= MTVEC_RESET[31:2];
            r_mepc         <= 30'b0;
            r_mcause       <= 32'b0;
        end else if (w_trap) begin
            r_mepc         <= x_pc_i[31:2];
            r_mcause       <= w_exc ? {28'b0, x_exception_cause_i} : irq_mcause(w_meip_pend);
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (w_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_csr_wr) begin
            case (x_csr_sel_i)
                CSR_MSTATUS: begin
                    r_mstatus_mie  <= x_csr_write_value_i[MSTATUS_MIE];
                    r_mstatus_mpie <= x_csr_write_value_i[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    r_mie_mtie <= x_csr_write_value_i[IRQ_MT];
                    r_mie_meie <= x_csr_write_value_i[IRQ_ME];
                end
                CSR_MTVEC:  r_mtvec  <= x_csr_write_value_i[31:2];
                CSR_MEPC:   r_mepc   <= x_csr_write_value_i[31:2];
                CSR_MCAUSE: r_mcause <= x_csr_write_value_i;
                default: ;
            endcase
        end
    end

    // Target is frozen at event time so later CSR changes cannot disturb the in-flight redirect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'b0;
        end else begin
            r_redirect <= w_trap || w_mret;
            if (w_trap) begin
                r_redirect_pc <= {r_mtvec, 2'b00};
            end else if (w_mret) begin
                r_redirect_pc <= {r_mepc, 2'b00};
            end
        end
    end

    assign x_redirect_o    = r_redirect;
    assign x_redirect_pc_o = r_redirect_pc;
    assign x_interrupt_o   = w_irq_take;

    always_comb begin
        csr_mstatus_o               = 32'b0;
        csr_mstatus_o[MSTATUS_MIE]  = r_mstatus_mie;
        csr_mstatus_o[MSTATUS_MPIE] = r_mstatus_mpie;
        csr_mie_o                   = 32'b0;
        csr_mie_o[IRQ_MT]           = r_mie_mtie;
        csr_mie_o[IRQ_ME]           = r_mie_meie;
        csr_mip_o                   = 32'b0;
        csr_mip_o[IRQ_MT]           = r_mtip;
        csr_mip_o[IRQ_ME]           = w_meip;
    end

    assign csr_mtvec_o  = {r_mtvec, 2'b00};
    assign csr_mepc_o   = {r_mepc, 2'b00};
    assign csr_mcause_o = r_mcause;

endmodule

// File: tb/tb_urv_trap_ctrl.sv
// Directed bench for urv_trap_ctrl: inputs change 1ns after posedge, outputs sampled 1-2ns after posedge.
module tb_urv_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        x_stall_i;
    logic        x_kill_i;
    logic [31:0] x_pc_i;
    logic        x_csr_write_i;
    logic [11:0] x_csr_sel_i;
    logic [31:0] x_csr_write_value_i;
    logic        x_exception_i;
    logic [3:0]  x_exception_cause_i;
    logic        x_is_mret_i;
    logic        irq_i;
    logic        timer_tick_i;
    logic        x_redirect_o;
    logic [31:0] x_redirect_pc_o;
    logic        x_interrupt_o;
    logic [31:0] csr_mstatus_o;
    logic [31:0] csr_mip_o;
    logic [31:0] csr_mie_o;
    logic [31:0] csr_mtvec_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mcause_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    urv_trap_ctrl #(
        .MTVEC_RESET (32'h0000_0008),
        .IRQ_SYNC    (1'b1)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .x_stall_i           (x_stall_i),
        .x_kill_i            (x_kill_i),
        .x_pc_i              (x_pc_i),
        .x_csr_write_i       (x_csr_write_i),
        .x_csr_sel_i         (x_csr_sel_i),
        .x_csr_write_value_i (x_csr_write_value_i),
        .x_exception_i       (x_exception_i),
        .x_exception_cause_i (x_exception_cause_i),
        .x_is_mret_i         (x_is_mret_i),
        .irq_i               (irq_i),
        .timer_tick_i        (timer_tick_i),
        .x_redirect_o        (x_redirect_o),
        .x_redirect_pc_o     (x_redirect_pc_o),
        .x_interrupt_o       (x_interrupt_o),
        .csr_mstatus_o       (csr_mstatus_o),
        .csr_mip_o           (csr_mip_o),
        .csr_mie_o           (csr_mie_o),
        .csr_mtvec_o         (csr_mtvec_o),
        .csr_mepc_o          (csr_mepc_o),
        .csr_mcause_o        (csr_mcause_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        x_stall_i           = 1'b0;
        x_kill_i            = 1'b0;
        x_csr_write_i       = 1'b0;
        x_csr_sel_i         = 12'h000;
        x_csr_write_value_i = 32'h0;
        x_exception_i       = 1'b0;
        x_exception_cause_i = 4'h0;
        x_is_mret_i         = 1'b0;
        timer_tick_i        = 1'b0;
    endtask

    task automatic csr_wr(input logic [11:0] sel, input logic [31:0] val);
        x_csr_write_i       = 1'b1;
        x_csr_sel_i         = sel;
        x_csr_write_value_i = val;
        step();
        x_csr_write_i       = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_i  = 1'b1;
        irq_i  = 1'b0;
        x_pc_i = 32'h0;
        repeat (3) step();
        rst_i = 1'b0;
        chk("rst_mtvec",    csr_mtvec_o,   32'h8);
        chk("rst_mstatus",  csr_mstatus_o, 32'h0);
        chk("rst_mie",      csr_mie_o,     32'h0);
        chk("rst_mip",      csr_mip_o,     32'h0);
        chk("rst_mepc",     csr_mepc_o,    32'h0);
        chk("rst_mcause",   csr_mcause_o,  32'h0);
        chk("rst_redirect", {31'b0, x_redirect_o}, 32'h0);

        // Killed write must not land.
        x_kill_i = 1'b1;
        csr_wr(12'h305, 32'h2000);
        x_kill_i = 1'b0;
        chk("kill_mtvec", csr_mtvec_o, 32'h8);

        csr_wr(12'h305, 32'h1003);
        chk("wr_mtvec", csr_mtvec_o, 32'h1000);
        csr_wr(12'h304, 32'hFFFF_FFFF);
        chk("wr_mie", csr_mie_o, 32'h880);
        csr_wr(12'h300, 32'h8);
        chk("wr_mstatus", csr_mstatus_o, 32'h8);

        // Synchronous exception.
        x_exception_i = 1'b1; x_exception_cause_i = 4'd2; x_pc_i = 32'h200;
        step();
        x_exception_i = 1'b0;
        chk("exc_redirect",    {31'b0, x_redirect_o}, 32'h1);
        chk("exc_redirect_pc", x_redirect_pc_o, 32'h1000);
        chk("exc_mepc",        csr_mepc_o,    32'h200);
        chk("exc_mcause",      csr_mcause_o,  32'h2);
        chk("exc_mstatus",     csr_mstatus_o, 32'h80);

        // Second exception and mret while in REDIRECT are ignored.
        x_exception_i = 1'b1; x_exception_cause_i = 4'd5; x_pc_i = 32'h444; x_is_mret_i = 1'b1;
        step();
        x_exception_i = 1'b0; x_is_mret_i = 1'b0;
        chk("redir_ign_pulse",  {31'b0, x_redirect_o}, 32'h0);
        chk("redir_ign_mcause", csr_mcause_o, 32'h2);
        chk("redir_ign_mepc",   csr_mepc_o,   32'h200);

        csr_wr(12'h300, 32'h8);
        chk("reenable_mstatus", csr_mstatus_o, 32'h8);

        // Both interrupts raised while stalled: nothing taken for three cycles.
        x_stall_i = 1'b1; irq_i = 1'b1; timer_tick_i = 1'b1;
        #1;
        chk("stall_no_take0", {31'b0, x_interrupt_o}, 32'h0);
        step();
        timer_tick_i = 1'b0;
        chk("stall_no_take1", {31'b0, x_interrupt_o}, 32'h0);
        step();
        step();
        chk("stall_mip",      csr_mip_o,    32'h880);
        chk("stall_no_take3", {31'b0, x_interrupt_o}, 32'h0);
        chk("stall_mcause",   csr_mcause_o, 32'h2);

        // First unstalled cycle takes MEIP.
        x_stall_i = 1'b0; x_pc_i = 32'h340;
        #1;
        chk("irq_take", {31'b0, x_interrupt_o}, 32'h1);
        step();
        irq_i = 1'b0;
        chk("irq_redirect_pc", x_redirect_pc_o, 32'h1000);
        chk("irq_mcause",      csr_mcause_o,  32'h8000_000B);
        chk("irq_mepc",        csr_mepc_o,    32'h340);
        chk("irq_mstatus",     csr_mstatus_o, 32'h80);
        step();

        x_is_mret_i = 1'b1;
        step();
        x_is_mret_i = 1'b0;
        chk("mret_redirect",    {31'b0, x_redirect_o}, 32'h1);
        chk("mret_redirect_pc", x_redirect_pc_o, 32'h340);
        chk("mret_mstatus",     csr_mstatus_o, 32'h88);
        chk("mret_mip",         csr_mip_o,     32'h80);

        // Back in IDLE: still-pending timer interrupt is taken.
        x_pc_i = 32'h380;
        step();
        chk("mti_take", {31'b0, x_interrupt_o}, 32'h1);
        step();
        chk("mti_mcause", csr_mcause_o, 32'h8000_0007);
        chk("mti_mepc",   csr_mepc_o,   32'h380);
        step();

        // Re-enable, stall 3 cycles, then exception beats the pending interrupt.
        csr_wr(12'h300, 32'h8);
        x_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall2_no_take", {31'b0, x_interrupt_o}, 32'h0);
            step();
        end
        chk("stall2_mcause", csr_mcause_o, 32'h8000_0007);
        x_stall_i = 1'b0; x_exception_i = 1'b1; x_exception_cause_i = 4'd4; x_pc_i = 32'h500;
        #1;
        chk("exc_beats_irq_pulse", {31'b0, x_interrupt_o}, 32'h0);
        step();
        x_exception_i = 1'b0;
        chk("exc_beats_irq_mcause", csr_mcause_o, 32'h4);
        chk("exc_beats_irq_mepc",   csr_mepc_o,   32'h500);
        chk("exc_beats_irq_redir",  {31'b0, x_redirect_o}, 32'h1);

        // Reset during REDIRECT.
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rst_redir_pulse",   {31'b0, x_redirect_o}, 32'h0);
        chk("rst_redir_mstatus", csr_mstatus_o, 32'h0);
        chk("rst_redir_mtvec",   csr_mtvec_o,   32'h8);
        step();
        chk("rst_redir_no_second", {31'b0, x_redirect_o}, 32'h0);

        // Tick and clearing mip write together: tick wins.
        timer_tick_i = 1'b1;
        csr_wr(12'h344, 32'h0);
        timer_tick_i = 1'b0;
        chk("tick_beats_clear", csr_mip_o, 32'h80);
        csr_wr(12'h344, 32'h0);
        chk("mip_clear", csr_mip_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
